// File: rtl/trap_controller.sv
// Machine-mode interrupt entry / MRET sequencer. It owns the trap CSRs and drives the pipeline flush and redirect.
// Build option: define TRAP_VECTORED_EN to make mtvec[1:0] writable and enable vectored interrupt targets.
//   state      | meaning
//   RUN        | normal execution, interrupt / MRET decisions are made here
//   TRAP_ENTER | trap_taken high, redirect to trap vector, held while stalled
//   MRET_EXIT  | mret_exec high, redirect to mepc, held while stalled
module trap_controller #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        irq_sw,
    input  logic        inst_valid_exe,
    input  logic [31:0] pc_exe,
    input  logic        is_mret_mem,
    input  logic        pc_sel_mem,
    input  logic        stall_pipl,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_hit,
    output logic        trap_taken,
    output logic        mret_exec,
    output logic [31:0] redirect_pc,
    output logic        irq_pending
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;
    localparam logic [31:0] MIE_MASK     = 32'h0000_0888;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        TRAP_ENTER = 2'd1,
        MRET_EXIT  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_ext_sync1;
    logic        r_ext_sync2;
    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic        r_trap_taken;
    logic        r_mret_exec;
    logic [31:0] r_redirect_pc;

    logic [31:0] w_mip;
    logic [31:0] w_pend;
    logic [3:0]  w_code;
    logic [31:0] w_mtvec_base;
    logic [31:0] w_trap_target;
    logic        w_take_irq;
    logic        w_take_mret;
    logic        w_decide;
    logic        w_wr_mstatus;
    logic        w_wr_mie;
    logic        w_wr_mtvec;
    logic        w_wr_mepc;
    logic        w_wr_mcause;

    assign w_mip = {20'b0, r_ext_sync2, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};
    assign w_pend = w_mip & r_mie;
    assign irq_pending = |w_pend;

    // Priority MEI > MSI > MTI
    always_comb begin
        w_code = 4'd7;
        if (w_pend[11])
            w_code = 4'd11;
        else if (w_pend[3])
            w_code = 4'd3;
    end

    assign w_mtvec_base = {r_mtvec[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    assign w_trap_target = (r_mtvec[1:0] == 2'b01) ? (w_mtvec_base + {26'b0, w_code, 2'b00})
                                                   : w_mtvec_base;
`else
    assign w_trap_target = w_mtvec_base;
`endif

    assign w_take_mret = (r_state == RUN) && is_mret_mem && !stall_pipl;
    assign w_take_irq  = (r_state == RUN) && irq_pending && r_mstatus_mie && inst_valid_exe
                         && !pc_sel_mem && !stall_pipl && !is_mret_mem;
    assign w_decide    = w_take_mret || w_take_irq;

    assign w_wr_mstatus = csr_we && (csr_addr == ADDR_MSTATUS);
    assign w_wr_mie     = csr_we && (csr_addr == ADDR_MIE);
    assign w_wr_mtvec   = csr_we && (csr_addr == ADDR_MTVEC);
    assign w_wr_mepc    = csr_we && (csr_addr == ADDR_MEPC);
    assign w_wr_mcause  = csr_we && (csr_addr == ADDR_MCAUSE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= RUN;
            r_ext_sync1    <= 1'b0;
            r_ext_sync2    <= 1'b0;
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= 32'b0;
`ifdef TRAP_VECTORED_EN
            r_mtvec        <= MTVEC_RESET;
`else
            r_mtvec        <= {MTVEC_RESET[31:2], 2'b00};
`endif
            r_mepc         <= 32'b0;
            r_mcause       <= 32'b0;
            r_trap_taken   <= 1'b0;
            r_mret_exec    <= 1'b0;
            r_redirect_pc  <= 32'b0;
        end else begin
            r_ext_sync1 <= irq_ext;
            r_ext_sync2 <= r_ext_sync1;

            if (w_wr_mie)
                r_mie <= csr_wdata & MIE_MASK;
            if (w_wr_mtvec)
`ifdef TRAP_VECTORED_EN
                r_mtvec <= csr_wdata;
`else
                r_mtvec <= {csr_wdata[31:2], 2'b00};
`endif
            // Hardware trap/MRET updates take precedence over software writes
            if (!w_decide) begin
                if (w_wr_mstatus) begin
                    r_mstatus_mie  <= csr_wdata[3];
                    r_mstatus_mpie <= csr_wdata[7];
                end
                if (w_wr_mepc)
                    r_mepc <= {csr_wdata[31:2], 2'b00};
                if (w_wr_mcause)
                    r_mcause <= csr_wdata;
            end

            case (r_state)
                RUN: begin
                    if (w_take_mret) begin
                        r_state        <= MRET_EXIT;
                        r_mret_exec    <= 1'b1;
                        r_redirect_pc  <= r_mepc;
                        r_mstatus_mie  <= r_mstatus_mpie;
                        r_mstatus_mpie <= 1'b1;
                    end else if (w_take_irq) begin
                        r_state        <= TRAP_ENTER;
                        r_trap_taken   <= 1'b1;
                        r_redirect_pc  <= w_trap_target;
                        r_mepc         <= {pc_exe[31:2], 2'b00};
                        r_mcause       <= {1'b1, 27'b0, w_code};
                        r_mstatus_mpie <= r_mstatus_mie;
                        r_mstatus_mie  <= 1'b0;
                    end
                end
                TRAP_ENTER, MRET_EXIT: begin
                    if (!stall_pipl) begin
                        r_state       <= RUN;
                        r_trap_taken  <= 1'b0;
                        r_mret_exec   <= 1'b0;
                        r_redirect_pc <= 32'b0;
                    end
                end
                default: begin
                    r_state       <= RUN;
                    r_trap_taken  <= 1'b0;
                    r_mret_exec   <= 1'b0;
                    r_redirect_pc <= 32'b0;
                end
            endcase
        end
    end

    always_comb begin
        csr_rdata = 32'b0;
        csr_hit   = 1'b1;
        case (csr_addr)
            ADDR_MSTATUS: csr_rdata = {24'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
            ADDR_MIE:     csr_rdata = r_mie;
            ADDR_MTVEC:   csr_rdata = r_mtvec;
            ADDR_MEPC:    csr_rdata = r_mepc;
            ADDR_MCAUSE:  csr_rdata = r_mcause;
            ADDR_MIP:     csr_rdata = w_mip;
            default:      csr_hit   = 1'b0;
        endcase
    end

    assign trap_taken  = r_trap_taken;
    assign mret_exec   = r_mret_exec;
    assign redirect_pc = r_redirect_pc;

endmodule
